// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the dmem_ls load/store data memory:
//   - access size encodings carried on req_size
//   - FSM state type (sweep / normal operation)
//   - data path width
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering for dmem_ls.
//   Store side : i_st_size, i_st_lane, i_st_wdata -> o_st_mask (byte enables),
//                o_st_data (store data replicated onto every candidate lane)
//   Load side  : i_ld_size, i_ld_lane, i_ld_unsigned, i_ld_word -> o_ld_data
//                (addressed lanes shifted to bit 0, then zero/sign extended)
// The load side is fed from registered request attributes because the memory
// read is synchronous; the store side is fed straight from the request.
// -----------------------------------------------------------------------------
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]        i_st_size,
  input  logic [1:0]        i_st_lane,
  input  logic [DATA_W-1:0] i_st_wdata,
  output logic [3:0]        o_st_mask,
  output logic [DATA_W-1:0] o_st_data,
  input  logic [1:0]        i_ld_size,
  input  logic [1:0]        i_ld_lane,
  input  logic              i_ld_unsigned,
  input  logic [DATA_W-1:0] i_ld_word,
  output logic [DATA_W-1:0] o_ld_data
);

  logic [DATA_W-1:0] w_ld_shift;

  // Replicating the data means every lane already carries the right bytes;
  // the mask alone decides which lanes are written.
  // Store mask and data replication.
  always_comb begin
    o_st_mask = 4'b0000;
    o_st_data = 32'h0000_0000;
    case (i_st_size)
      SZ_BYTE: begin
        o_st_mask = 4'b0001 << i_st_lane;
        o_st_data = {4{i_st_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_st_mask = i_st_lane[1] ? 4'b1100 : 4'b0011;
        o_st_data = {2{i_st_wdata[15:0]}};
      end
      SZ_WORD: begin
        o_st_mask = 4'b1111;
        o_st_data = i_st_wdata;
      end
      default: begin
        o_st_mask = 4'b0000;
        o_st_data = 32'h0000_0000;
      end
    endcase
  end

  // Word loads always arrive with lane 0, so the shift is a no-op for them.
  assign w_ld_shift = i_ld_word >> {i_ld_lane, 3'b000};

  // Load extraction and extension.
  always_comb begin
    o_ld_data = 32'h0000_0000;
    case (i_ld_size)
      SZ_BYTE: begin
        if (i_ld_unsigned) begin
          o_ld_data = {24'h00_0000, w_ld_shift[7:0]};
        end else begin
          o_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
        end
      end
      SZ_HALF: begin
        if (i_ld_unsigned) begin
          o_ld_data = {16'h0000, w_ld_shift[15:0]};
        end else begin
          o_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
        end
      end
      SZ_WORD: begin
        o_ld_data = w_ld_shift;
      end
      default: begin
        o_ld_data = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ls.sv
// -----------------------------------------------------------------------------
// dmem_ls
// Single-port load/store data memory with byte/half/word access, alignment and
// range checking, fixed one-cycle response latency and an optional zero-fill
// sweep after reset.
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only outside the sweep)
//   req_we, req_size,
//   req_unsigned,
//   req_addr, req_wdata   : request attributes (byte address, right-aligned data)
//   rsp_valid, rsp_rdata,
//   rsp_err               : one-cycle response pulse; data/err zero when idle
//   busy                  : high while the zero-fill sweep runs
// -----------------------------------------------------------------------------
module dmem_ls
  import dmem_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_clr_idx;
  logic [AW-1:0]     w_clr_idx_nxt;

  logic              w_accept;
  logic [AW-1:0]     w_idx;
  logic [1:0]        w_lane;
  logic [31:0]       w_hi_bits;
  logic              w_hi_err;
  logic              w_size_err;
  logic              w_err;

  logic [3:0]        w_st_mask;
  logic [DATA_W-1:0] w_st_data;
  logic [DATA_W-1:0] w_ld_data;

  logic              w_wr_en;
  logic [AW-1:0]     w_wr_idx;
  logic [3:0]        w_wr_mask;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_rd_en;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_rd_word;

  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              r_rsp_load;
  logic [1:0]        r_ld_size;
  logic [1:0]        r_ld_lane;
  logic              r_ld_unsigned;

  // FSM state and sweep counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      r_clr_idx <= {AW{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // Next-state logic: step one word per cycle, leave after the last index.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_idx == LAST_IDX) begin
          w_state_nxt   = ST_RUN;
          w_clr_idx_nxt = {AW{1'b0}};
        end else begin
          w_clr_idx_nxt = r_clr_idx + AW'(1);
        end
      end
      ST_RUN: begin
        w_state_nxt = ST_RUN;
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_idx_nxt = {AW{1'b0}};
      end
    endcase
  end

  assign req_ready = (r_state == ST_RUN);
  assign busy      = (r_state == ST_CLEAR);

  assign w_accept  = req_valid & req_ready;
  assign w_idx     = req_addr[AW+1:2];
  assign w_lane    = req_addr[1:0];
  // Anything above the word index range is outside the array.
  assign w_hi_bits = req_addr >> (AW + 2);
  assign w_hi_err  = |w_hi_bits;

  // Size and alignment legality.
  always_comb begin
    w_size_err = 1'b0;
    case (req_size)
      SZ_BYTE: w_size_err = 1'b0;
      SZ_HALF: w_size_err = req_addr[0];
      SZ_WORD: w_size_err = |req_addr[1:0];
      default: w_size_err = 1'b1;
    endcase
  end

  assign w_err = w_size_err | w_hi_err;

  dmem_lane_align u_lane_align (
    .i_st_size     (req_size),
    .i_st_lane     (w_lane),
    .i_st_wdata    (req_wdata),
    .o_st_mask     (w_st_mask),
    .o_st_data     (w_st_data),
    .i_ld_size     (r_ld_size),
    .i_ld_lane     (r_ld_lane),
    .i_ld_unsigned (r_ld_unsigned),
    .i_ld_word     (r_rd_word),
    .o_ld_data     (w_ld_data)
  );

  // Single write port shared between the sweep and accepted stores.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = w_idx;
    w_wr_mask = 4'b0000;
    w_wr_data = 32'h0000_0000;
    if (r_state == ST_CLEAR) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = r_clr_idx;
      w_wr_mask = 4'b1111;
      w_wr_data = 32'h0000_0000;
    end else begin
      w_wr_en   = w_accept & req_we & ~w_err;
      w_wr_idx  = w_idx;
      w_wr_mask = w_st_mask;
      w_wr_data = w_st_data;
    end
  end

  assign w_rd_en = w_accept & ~req_we & ~w_err;

  // Memory array: byte-enabled synchronous write, synchronous read, no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_mask[i]) begin
          r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
        end
      end
    end
    if (w_rd_en) begin
      r_rd_word <= r_mem[w_idx];
    end
  end

  // Response pipeline stage: capture attributes needed to shape the load data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_rsp_load    <= 1'b0;
      r_ld_size     <= SZ_WORD;
      r_ld_lane     <= 2'b00;
      r_ld_unsigned <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      if (w_accept) begin
        r_rsp_err     <= w_err;
        r_rsp_load    <= ~req_we & ~w_err;
        r_ld_size     <= req_size;
        r_ld_lane     <= w_lane;
        r_ld_unsigned <= req_unsigned;
      end else begin
        r_rsp_err     <= 1'b0;
        r_rsp_load    <= 1'b0;
        r_ld_size     <= r_ld_size;
        r_ld_lane     <= r_ld_lane;
        r_ld_unsigned <= r_ld_unsigned;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_valid & r_rsp_err;
  // Stores and rejected requests return zero data.
  assign rsp_rdata = (r_rsp_valid & r_rsp_load) ? w_ld_data : 32'h0000_0000;

endmodule

// File: doc/dmem_ls.md
DMEM_LS -- requirements
Module: dmem_ls

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit words (power of two, 4..65536).
REQ-002 Parameter CLEAR_ON_RESET, default 1; 1 = zero-fill sweep after reset, 0 = skip the sweep.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  block accepts a request this cycle.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 Port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 Port req_addr  input  32  byte address.
REQ-011 Port req_wdata  input  32  store data, right-aligned in bits [7:0], [15:0] or [31:0].
REQ-012 Port rsp_valid  output  1  single-cycle response pulse.
REQ-013 Port rsp_rdata  output  32  load result, extended to 32 bits.
REQ-014 Port rsp_err  output  1  request was rejected (qualified by rsp_valid).
REQ-015 Port busy  output  1  high during the clear sweep.

Function
REQ-016 Handshake: request accepted when req_valid && req_ready; req_ready = 1 in RUN, 0 in CLEAR.
REQ-017 FSM states: CLEAR and RUN. Reset enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
REQ-018 CLEAR: one word index per cycle, 0..DEPTH-1, writing 32'h0; enter RUN the cycle after index DEPTH-1 is written; the sweep takes exactly DEPTH cycles.
REQ-019 Fixed latency: rsp_valid rises exactly 1 cycle after acceptance; one request per cycle sustained; no response backpressure.
REQ-020 Word index = req_addr[log2(DEPTH)+1:2]; byte lane = req_addr[1:0].
REQ-021 Error when any of: req_size=11; half with addr[0]=1; word with addr[1:0]!=0; req_addr[31:log2(DEPTH)+2] nonzero.
REQ-022 Error response: rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-023 Store: write only the addressed lanes (byte: 1 lane, half: 2 lanes, word: 4 lanes); response has rsp_err=0, rsp_rdata=0.
REQ-024 Load: extract the addressed lanes, shift them to bit 0, then zero- or sign-extend per req_unsigned; word loads ignore req_unsigned.
REQ-025 Store then load to the same word in the next cycle returns the updated data (write is visible by the next read).
REQ-026 When rsp_valid=0, rsp_rdata=0 and rsp_err=0.

Reset
REQ-027 Asynchronous reset drives rsp_valid=0, rsp_rdata=0, rsp_err=0, and the sweep counter to 0.
REQ-028 On reset, req_ready=0 and busy=1 if CLEAR_ON_RESET=1; otherwise req_ready=1 and busy=0.
REQ-029 Reset asserted during a sweep restarts the sweep from index 0; an in-flight response is dropped.
REQ-030 Memory array contents are not reset directly; zeroing happens only through the sweep.

Structure
REQ-031 Package dmem_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state type, and the data width constant 32.
REQ-032 Sub-module dmem_lane_align holds the combinational store lane mask, store data replication, and load extraction/extension.
REQ-033 The memory is a synchronous-write, synchronous-read array inferable as block RAM.

Verification
REQ-034 Reset with DEPTH=16, CLEAR_ON_RESET=1 -> busy high for 16 cycles, req_ready rises on cycle 17, load of 0x3C returns 0.
REQ-035 Store word 0xDEADBEEF at 0x8, then load byte at 0xB signed -> 0xFFFFFFDE; load byte unsigned -> 0x000000DE; load half at 0xA signed -> 0xFFFFDEAD.
REQ-036 Store byte 0x55 at 0x9 over 0xDEADBEEF -> load word at 0x8 returns 0xDEAD55EF.
REQ-037 Load half at 0x5, load word at 0x6, req_size=11, address 0x40 with DEPTH=16 -> each gives rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-038 Back-to-back: store 0x12345678 at 0x0 in cycle N, load 0x0 in cycle N+1 -> rsp_valid in N+1 and N+2, second response rdata=0x12345678.
REQ-039 Assert reset at sweep index 7 -> after release, busy lasts a full DEPTH cycles again and no rsp_valid appears.
